// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core back end: writeback source codes,
// load funct3 encodings and the writeback FSM state type.
package core_pkg;

    localparam logic [1:0] WB_SRC_NONE = 2'b00;
    localparam logic [1:0] WB_SRC_ALU  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;
    localparam logic [1:0] WB_SRC_LOAD = 2'b11;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection and sign/zero extension; also flags
// misaligned accesses and funct3 codes that are not legal loads.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_word,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr, 3'b000} +: 8];
    assign w_half = i_word[{i_addr[1], 4'b0000} +: 16];

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_data       = '0;
        o_misaligned = 1'b0;
        case (i_funct3)
            LOAD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: o_data = {24'd0, w_byte};
            LOAD_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr[0];
            end
            LOAD_LHU: begin
                o_data       = {16'd0, w_half};
                o_misaligned = i_addr[0];
            end
            LOAD_LW: begin
                o_data       = i_word;
                o_misaligned = |i_addr;
            end
            default:  o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: retires ALU, PC+4 and load results, with
// misaligned-load and memory-timeout error pulses.
module writeback_unit
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_src,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_instr_addr,
    input  logic [2:0]  in_funct3,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err_misaligned,
    output logic        err_timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    wb_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr;
    logic        r_rf_we, r_err_mis, r_err_to;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        w_write, w_we, w_capture, w_err_mis, w_err_to;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic [2:0]  w_la_funct3;
    logic [1:0]  w_la_addr;
    logic [31:0] w_la_data;
    logic        w_la_mis;

    // In IDLE the aligner checks the offered instruction; afterwards it
    // extends the returning word using the captured address and width.
    assign w_la_funct3 = (r_state == WB_IDLE) ? in_funct3 : r_funct3;
    assign w_la_addr   = (r_state == WB_IDLE) ? in_alu_result[1:0] : r_addr;

    load_align u_load_align (
        .i_funct3     (w_la_funct3),
        .i_addr       (w_la_addr),
        .i_word       (mem_rdata),
        .o_data       (w_la_data),
        .o_misaligned (w_la_mis)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_write     = 1'b0;
        w_waddr     = r_rd;
        w_wdata     = w_la_data;
        w_capture   = 1'b0;
        w_err_mis   = 1'b0;
        w_err_to    = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (in_valid) begin
                    w_capture = 1'b1;
                    w_waddr   = in_rd;
                    case (in_src)
                        WB_SRC_ALU: begin
                            w_write     = 1'b1;
                            w_wdata     = in_alu_result;
                            w_state_nxt = WB_WRITE;
                        end
                        WB_SRC_PC4: begin
                            w_write     = 1'b1;
                            w_wdata     = in_instr_addr + 32'd4;
                            w_state_nxt = WB_WRITE;
                        end
                        WB_SRC_LOAD: begin
                            if (w_la_mis) w_err_mis   = 1'b1;
                            else          w_state_nxt = WB_WAIT_MEM;
                        end
                        default: ;
                    endcase
                end
            end
            WB_WAIT_MEM: begin
                // A response on the final count still wins over the timeout.
                if (mem_rvalid) begin
                    w_write     = 1'b1;
                    w_state_nxt = WB_WRITE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_to    = 1'b1;
                    w_state_nxt = WB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WB_WRITE: w_state_nxt = WB_IDLE;
            default:  w_state_nxt = WB_IDLE;
        endcase
    end

    // x0 is hardwired to zero, so a write to it is dropped entirely.
    assign w_we = w_write && (w_waddr != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WB_IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_err_mis  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rf_we   <= w_we;
            r_err_mis <= w_err_mis;
            r_err_to  <= w_err_to;
            if (w_we) begin
                r_rf_waddr <= w_waddr;
                r_rf_wdata <= w_wdata;
            end
            if (w_capture) begin
                r_rd     <= in_rd;
                r_funct3 <= in_funct3;
                r_addr   <= in_alu_result[1:0];
            end
        end
    end

    assign in_ready       = (r_state == WB_IDLE);
    assign rf_we          = r_rf_we;
    assign rf_waddr       = r_rf_waddr;
    assign rf_wdata       = r_rf_wdata;
    assign err_misaligned = r_err_mis;
    assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scoreboard bench for writeback_unit (MEM_TIMEOUT=4): stimulus
// pushes expected events with their cycle, a negedge monitor pops and compares.
module tb_writeback_unit;

    localparam int TMO = 4;
    localparam logic [31:0] RDATA = 32'h80F07F01;

    localparam int EV_WR  = 1;
    localparam int EV_MIS = 2;
    localparam int EV_TO  = 4;

    typedef struct {
        int          code;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_src;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_instr_addr;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err_misaligned;
    logic        err_timeout;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q[$];

    writeback_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_src         (in_src),
        .in_rd          (in_rd),
        .in_alu_result  (in_alu_result),
        .in_instr_addr  (in_instr_addr),
        .in_funct3      (in_funct3),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .err_misaligned (err_misaligned),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int code, input logic [4:0] addr, input logic [31:0] data, input int at);
        exp_t e;
        e.code = code;
        e.addr = addr;
        e.data = data;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // Offers one instruction; acc is the cycle count right after acceptance.
    task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [2:0] f3, output int acc);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        in_src        = src;
        in_rd         = rd;
        in_alu_result = alu;
        in_instr_addr = pc;
        in_funct3     = f3;
        tick();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    // Load whose response arrives dly cycles after acceptance.
    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                           input int dly, input logic [31:0] exp);
        int acc;
        issue(2'b11, rd, addr, 32'h0, f3, acc);
        repeat (dly - 1) tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("load_latency", cyc - acc, dly);
        push_ev(EV_WR, rd, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] code;
            code = {29'd0, err_timeout, err_misaligned, rf_we};
            if (code != 0) begin
                if (q.size() == 0) begin
                    check("unexpected_event", code, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event_kind", code, e.code);
                    check("event_cycle", cyc, e.cyc);
                    if (e.code == EV_WR) begin
                        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                        check("rf_wdata", rf_wdata, e.data);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                exp_t e;
                e = q.pop_front();
                check("missed_event", 32'd0, e.code);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_src        = 2'b00;
        in_rd         = 5'd0;
        in_alu_result = 32'h0;
        in_instr_addr = 32'h0;
        in_funct3     = 3'b000;
        mem_rvalid    = 1'b0;
        mem_rdata     = RDATA;
        repeat (3) tick();
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_waddr", {27'd0, rf_waddr}, 32'd0);
        check("reset_wdata", rf_wdata, 32'd0);
        check("reset_errs", {30'd0, err_misaligned, err_timeout}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU write and ready timing
        issue(2'b01, 5'd5, 32'hDEADBEEF, 32'h0, 3'b000, acc);
        push_ev(EV_WR, 5'd5, 32'hDEADBEEF, acc);
        check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        tick();
        check("ready_high_after", {31'd0, in_ready}, 32'd1);

        // PC+4, including wrap and x0 suppression
        issue(2'b10, 5'd1, 32'h0, 32'hFFFFFFFC, 3'b000, acc);
        push_ev(EV_WR, 5'd1, 32'h00000000, acc);
        issue(2'b10, 5'd2, 32'h0, 32'h00001000, 3'b000, acc);
        push_ev(EV_WR, 5'd2, 32'h00001004, acc);
        issue(2'b10, 5'd0, 32'h0, 32'h00002000, 3'b000, acc);
        check("x0_no_we", {31'd0, rf_we}, 32'd0);
        check("hold_waddr", {27'd0, rf_waddr}, 32'd2);
        check("hold_wdata", rf_wdata, 32'h00001004);

        // No-write source stays in IDLE
        issue(2'b00, 5'd3, 32'h12345678, 32'h0, 3'b000, acc);
        check("none_ready", {31'd0, in_ready}, 32'd1);

        // Load extension on 0x80F07F01
        do_load(5'd10, 32'h10000003, 3'b000, 1, 32'hFFFFFF80);
        do_load(5'd11, 32'h10000002, 3'b100, 2, 32'h000000F0);
        do_load(5'd12, 32'h10000002, 3'b001, 3, 32'hFFFF80F0);
        do_load(5'd13, 32'h10000000, 3'b101, 1, 32'h00007F01);
        do_load(5'd14, 32'h10000000, 3'b010, 3, 32'h80F07F01);

        // Misaligned and illegal loads
        issue(2'b11, 5'd7, 32'h20000002, 32'h0, 3'b010, acc);
        push_ev(EV_MIS, 5'd0, 32'h0, acc);
        check("mis_ready_lw", {31'd0, in_ready}, 32'd1);
        issue(2'b11, 5'd8, 32'h20000001, 32'h0, 3'b001, acc);
        push_ev(EV_MIS, 5'd0, 32'h0, acc);
        check("mis_ready_lh", {31'd0, in_ready}, 32'd1);
        issue(2'b11, 5'd9, 32'h20000000, 32'h0, 3'b011, acc);
        push_ev(EV_MIS, 5'd0, 32'h0, acc);

        // Timeout, then a late response that must be ignored
        issue(2'b11, 5'd15, 32'h30000000, 32'h0, 3'b010, acc);
        push_ev(EV_TO, 5'd0, 32'h0, acc + TMO);
        repeat (TMO + 1) tick();
        check("timeout_ready", {31'd0, in_ready}, 32'd1);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();

        // Response on the final count wins
        do_load(5'd16, 32'h30000000, 3'b010, TMO, 32'h80F07F01);
        tick();

        // Reset while waiting for memory
        issue(2'b11, 5'd17, 32'h40000000, 32'h0, 3'b010, acc);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_mid_wdata", rf_wdata, 32'd0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("rst_mid_no_we", {31'd0, rf_we}, 32'd0);
        check("rst_mid_errs", {30'd0, err_misaligned, err_timeout}, 32'd0);
        tick();
        check("rst_mid_still_no_we", {31'd0, rf_we}, 32'd0);

        repeat (8) tick();
        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
